// File: rtl/bus8088_pkg.sv
// ============================================================================
// Module   : bus8088_pkg
// Brief    : Shared types, constants and helpers for the 8088 bus controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bus8088_pkg;

    localparam int ADDR_W     = 20;
    localparam int DATA_W     = 8;
    localparam int CFG_WAIT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } bus_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]     base;
        logic [ADDR_W-1:0]     mask;
        logic                  io;
        logic [CFG_WAIT_W-1:0] wait_cnt;
    } region_cfg_t;

    function automatic logic [31:0] onehot(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_region_decode.sv
// ============================================================================
// Module   : bus_region_decode
// Brief    : Combinational address/space decode against NUM_CS regions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_region_decode
    import bus8088_pkg::*;
#(
    parameter int                         NUM_CS      = 4,
    parameter int                         WAIT_W      = 3,
    parameter int                         IDX_W       = 2,
    parameter logic [NUM_CS*ADDR_W-1:0]   REGION_BASE = '0,
    parameter logic [NUM_CS*ADDR_W-1:0]   REGION_MASK = '0,
    parameter logic [NUM_CS-1:0]          REGION_IO   = '0,
    parameter logic [NUM_CS*WAIT_W-1:0]   REGION_WAIT = '0
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_io,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx,
    output logic [WAIT_W-1:0] o_wait
);

    region_cfg_t             w_cfg   [NUM_CS];
    logic        [NUM_CS-1:0] w_match;

    // Parameter vectors list region 0 in the most-significant slot.
    for (genvar i = 0; i < NUM_CS; i++) begin : g_region
        logic [ADDR_W-1:0] w_mask;

        assign w_cfg[i].base     = REGION_BASE[(NUM_CS-1-i)*ADDR_W +: ADDR_W];
        assign w_cfg[i].mask     = REGION_MASK[(NUM_CS-1-i)*ADDR_W +: ADDR_W];
        assign w_cfg[i].io       = REGION_IO[i];
        assign w_cfg[i].wait_cnt = CFG_WAIT_W'(REGION_WAIT[(NUM_CS-1-i)*WAIT_W +: WAIT_W]);

        // IO space is only 64K, so the top nibble never takes part.
        assign w_mask     = w_cfg[i].io ? (w_cfg[i].mask & 20'h0FFFF) : w_cfg[i].mask;
        assign w_match[i] = ((i_addr & w_mask) == (w_cfg[i].base & w_mask)) &&
                            (i_io == w_cfg[i].io);
    end

    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        o_wait = '0;
        // Walk downwards so the lowest matching index is the one that sticks.
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit  = 1'b1;
                o_idx  = IDX_W'(i);
                o_wait = WAIT_W'(w_cfg[i].wait_cnt);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_cs_wait_ctrl.sv
// ============================================================================
// Module   : bus_cs_wait_ctrl
// Brief    : 8088 min-mode cycle controller: address latch, CS decode, waits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_cs_wait_ctrl
    import bus8088_pkg::*;
#(
    parameter int                       NUM_CS      = 4,
    parameter int                       WAIT_W      = 3,
    parameter logic [NUM_CS*ADDR_W-1:0] REGION_BASE = {20'h00000, 20'h10000, 20'h00000, 20'h00010},
    parameter logic [NUM_CS*ADDR_W-1:0] REGION_MASK = {20'hF0000, 20'hF0000, 20'h0FFF0, 20'h0FFF0},
    parameter logic [NUM_CS-1:0]        REGION_IO   = 4'b1100,
    parameter logic [NUM_CS*WAIT_W-1:0] REGION_WAIT = {3'd0, 3'd2, 3'd1, 3'd3}
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ALE,
    input  logic                     IOM,
    input  logic                     RD,
    input  logic                     WR,
    input  logic [DATA_W-1:0]        AD,
    input  logic [ADDR_W-DATA_W-1:0] A,
    output logic [ADDR_W-1:0]        Address,
    output logic [NUM_CS-1:0]        CS,
    output logic                     READY,
    output logic                     cycle_active,
    output logic                     decode_err
);

    localparam int         IDX_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam logic [1:0] c_st_idle  = S_IDLE;
    localparam logic [1:0] c_st_addr  = S_ADDR;
    localparam logic [1:0] c_st_wait  = S_WAIT;
    localparam logic [1:0] c_st_done  = S_DONE;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_io;
    logic [NUM_CS-1:0] r_cs;
    logic              r_ready;
    logic              r_active;
    logic              r_err;
    logic [WAIT_W-1:0] r_cnt;

    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic [WAIT_W-1:0] w_wait;
    logic              w_strobe_one;
    logic              w_strobe_both;
    logic              w_released;
    logic [NUM_CS-1:0] w_cs_sel;

    bus_region_decode #(
        .NUM_CS      (NUM_CS),
        .WAIT_W      (WAIT_W),
        .IDX_W       (IDX_W),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK),
        .REGION_IO   (REGION_IO),
        .REGION_WAIT (REGION_WAIT)
    ) u_decode (
        .i_addr (r_addr),
        .i_io   (r_io),
        .o_hit  (w_hit),
        .o_idx  (w_idx),
        .o_wait (w_wait)
    );

    assign w_strobe_one  = RD ^ WR;
    assign w_strobe_both = !RD && !WR;
    assign w_released    = RD && WR;
    assign w_cs_sel      = NUM_CS'(onehot(5'(w_idx)));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= c_st_idle;
            r_addr   <= '0;
            r_io     <= 1'b0;
            r_cs     <= '0;
            r_ready  <= 1'b1;
            r_active <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_err <= 1'b0;
            if (ALE) begin
                r_addr <= {A, AD};
                r_io   <= IOM;
            end

            case (r_state)
                c_st_idle: begin
                    if (ALE) r_state <= c_st_addr;
                end

                c_st_addr: begin
                    // A fresh ALE only re-latches; strobes are judged on the settled address.
                    if (!ALE) begin
                        if (w_strobe_both) begin
                            r_err    <= 1'b1;
                            r_cs     <= '0;
                            r_active <= 1'b1;
                            r_state  <= c_st_done;
                        end else if (w_strobe_one) begin
                            r_active <= 1'b1;
                            if (!w_hit) begin
                                r_err   <= 1'b1;
                                r_state <= c_st_done;
                            end else begin
                                r_cs <= w_cs_sel;
                                if (w_wait == '0) begin
                                    r_state <= c_st_done;
                                end else begin
                                    r_ready <= 1'b0;
                                    r_cnt   <= w_wait - WAIT_W'(1);
                                    r_state <= c_st_wait;
                                end
                            end
                        end
                    end
                end

                c_st_wait: begin
                    if (ALE) begin
                        r_cs     <= '0;
                        r_ready  <= 1'b1;
                        r_active <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= c_st_addr;
                    end else if (r_cnt == '0) begin
                        r_ready <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt - WAIT_W'(1);
                    end
                end

                c_st_done: begin
                    if (w_released) begin
                        r_cs     <= '0;
                        r_active <= 1'b0;
                        r_state  <= ALE ? c_st_addr : c_st_idle;
                    end else if (ALE) begin
                        // New cycle started while strobes still held: abort.
                        r_cs     <= '0;
                        r_ready  <= 1'b1;
                        r_active <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= c_st_addr;
                    end
                end

                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign Address      = r_addr;
    assign CS           = r_cs;
    assign READY        = r_ready;
    assign cycle_active = r_active;
    assign decode_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bus_cs_wait_ctrl.sv
// ============================================================================
// Module   : tb_bus_cs_wait_ctrl
// Brief    : Self-checking bench for bus_cs_wait_ctrl with expectation queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_cs_wait_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ale = 1'b0;
    logic        iom = 1'b0;
    logic        rd = 1'b1;
    logic        wr = 1'b1;
    logic [7:0]  ad = '0;
    logic [11:0] a = '0;
    logic [19:0] address;
    logic [3:0]  cs;
    logic        ready;
    logic        cycle_active;
    logic        decode_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [19:0] addr;
        logic [3:0]  cs;
        int          rlow;
        int          errs;
    } exp_t;

    exp_t exp_q[$];

    bus_cs_wait_ctrl dut (
        .CLK          (clk),
        .RESET        (rst_n),
        .ALE          (ale),
        .IOM          (iom),
        .RD           (rd),
        .WR           (wr),
        .AD           (ad),
        .A            (a),
        .Address      (address),
        .CS           (cs),
        .READY        (ready),
        .cycle_active (cycle_active),
        .decode_err   (decode_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // Runs one complete bus cycle and reports what the DUT did.
    task automatic run_cycle(input logic [19:0] addr, input logic io, input logic rd_l, input logic wr_l,
                             output logic [19:0] o_addr, output logic [3:0] o_cs, output int o_rlow,
                             output int o_errs, output logic o_act_hold, output logic [3:0] o_cs_rel,
                             output logic o_act_rel);
        int n;
        o_rlow = 0;
        o_errs = 0;
        n = 0;
        ale = 1'b1; ad = addr[7:0]; a = addr[19:8]; iom = io;
        @(posedge clk); #1;
        o_addr = address;
        ale = 1'b0; rd = rd_l; wr = wr_l;
        @(posedge clk); #1;
        o_cs = cs;
        if (decode_err) o_errs++;
        while (ready !== 1'b1 && n < 20) begin
            o_rlow++;
            n++;
            @(posedge clk); #1;
            if (decode_err) o_errs++;
        end
        o_act_hold = cycle_active;
        rd = 1'b1; wr = 1'b1;
        @(posedge clk); #1;
        if (decode_err) o_errs++;
        o_cs_rel = cs;
        o_act_rel = cycle_active;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (address !== 20'h0) begin miscompares++; $display("FAIL reset addr: got %05h expected 00000", address); end
        vectors++; if (cs !== 4'b0) begin miscompares++; $display("FAIL reset cs: got %b expected 0000", cs); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset ready: got %b expected 1", ready); end
        vectors++; if (cycle_active !== 1'b0) begin miscompares++; $display("FAIL reset active: got %b expected 0", cycle_active); end
        vectors++; if (decode_err !== 1'b0) begin miscompares++; $display("FAIL reset err: got %b expected 0", decode_err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drives every vector in the table through run_cycle and scores it.
    task automatic test_cycles(input string tag, input logic [19:0] t_addr [], input logic t_io [],
                               input logic t_rd [], input logic t_wr [], input logic [3:0] t_cs [],
                               input int t_rlow [], input int t_errs []);
        logic [19:0] o_addr;
        logic [3:0]  o_cs, o_cs_rel;
        int          o_rlow, o_errs;
        logic        o_act_hold, o_act_rel;
        exp_t        e;
        for (int i = 0; i < t_addr.size(); i++) begin
            exp_q.push_back('{addr: t_addr[i], cs: t_cs[i], rlow: t_rlow[i], errs: t_errs[i]});
            run_cycle(t_addr[i], t_io[i], t_rd[i], t_wr[i], o_addr, o_cs, o_rlow, o_errs,
                      o_act_hold, o_cs_rel, o_act_rel);
            e = exp_q.pop_front();
            vectors++; if (o_addr !== e.addr) begin miscompares++; $display("FAIL %s[%0d] addr: got %05h expected %05h", tag, i, o_addr, e.addr); end
            vectors++; if (o_cs !== e.cs) begin miscompares++; $display("FAIL %s[%0d] cs: got %b expected %b", tag, i, o_cs, e.cs); end
            vectors++; if (o_rlow !== e.rlow) begin miscompares++; $display("FAIL %s[%0d] ready_low: got %0d expected %0d", tag, i, o_rlow, e.rlow); end
            vectors++; if (o_errs !== e.errs) begin miscompares++; $display("FAIL %s[%0d] err_pulses: got %0d expected %0d", tag, i, o_errs, e.errs); end
            vectors++; if (o_act_hold !== 1'b1) begin miscompares++; $display("FAIL %s[%0d] active_hold: got %b expected 1", tag, i, o_act_hold); end
            vectors++; if (o_cs_rel !== 4'b0) begin miscompares++; $display("FAIL %s[%0d] cs_release: got %b expected 0000", tag, i, o_cs_rel); end
            vectors++; if (o_act_rel !== 1'b0) begin miscompares++; $display("FAIL %s[%0d] active_release: got %b expected 0", tag, i, o_act_rel); end
        end
    endtask

    task automatic test_mem_read();
        test_cycles("mem_read", '{20'h04123}, '{1'b0}, '{1'b0}, '{1'b1}, '{4'b0001}, '{0}, '{0});
    endtask

    task automatic test_regions();
        test_cycles("regions", '{20'h12345, 20'h00013, 20'h00005}, '{1'b0, 1'b1, 1'b1},
                    '{1'b1, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1}, '{4'b0010, 4'b1000, 4'b0100},
                    '{2, 3, 1}, '{0, 0, 0});
    endtask

    task automatic test_decode_err();
        test_cycles("decode_err", '{20'hF0000, 20'h00000}, '{1'b0, 1'b0}, '{1'b0, 1'b0},
                    '{1'b1, 1'b0}, '{4'b0000, 4'b0000}, '{0, 0}, '{1, 1});
    endtask

    task automatic test_abort();
        ale = 1'b1; ad = 8'h00; a = 12'h100; iom = 1'b0;
        @(posedge clk); #1;
        ale = 1'b0; rd = 1'b0;
        @(posedge clk); #1;
        vectors++; if (cs !== 4'b0010 || ready !== 1'b0) begin miscompares++; $display("FAIL abort setup: got cs=%b ready=%b expected cs=0010 ready=0", cs, ready); end
        ale = 1'b1; ad = 8'h00; a = 12'h040; rd = 1'b1;
        @(posedge clk); #1;
        vectors++; if (cs !== 4'b0) begin miscompares++; $display("FAIL abort cs: got %b expected 0000", cs); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL abort ready: got %b expected 1", ready); end
        vectors++; if (cycle_active !== 1'b0) begin miscompares++; $display("FAIL abort active: got %b expected 0", cycle_active); end
        vectors++; if (decode_err !== 1'b1) begin miscompares++; $display("FAIL abort err: got %b expected 1", decode_err); end
        vectors++; if (address !== 20'h04000) begin miscompares++; $display("FAIL abort addr: got %05h expected 04000", address); end
        ale = 1'b0; rd = 1'b0;
        @(posedge clk); #1;
        vectors++; if (cs !== 4'b0001 || decode_err !== 1'b0) begin miscompares++; $display("FAIL abort next cs/err: got %b/%b expected 0001/0", cs, decode_err); end
        rd = 1'b1;
        @(posedge clk); #1;
        vectors++; if (cs !== 4'b0) begin miscompares++; $display("FAIL abort next release: got %b expected 0000", cs); end
    endtask

    task automatic test_back_to_back();
        ale = 1'b1; ad = 8'h23; a = 12'h041; iom = 1'b0;
        @(posedge clk); #1;
        ale = 1'b0; rd = 1'b0;
        @(posedge clk); #1;
        vectors++; if (cs !== 4'b0001) begin miscompares++; $display("FAIL b2b first cs: got %b expected 0001", cs); end
        rd = 1'b1; ale = 1'b1; ad = 8'h45; a = 12'h123;
        @(posedge clk); #1;
        vectors++; if (cs !== 4'b0 || decode_err !== 1'b0 || address !== 20'h12345) begin miscompares++; $display("FAIL b2b handoff: got cs=%b err=%b addr=%05h expected 0000/0/12345", cs, decode_err, address); end
        ale = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        vectors++; if (cs !== 4'b0010 || ready !== 1'b0) begin miscompares++; $display("FAIL b2b second: got cs=%b ready=%b expected 0010/0", cs, ready); end
        wr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (cs !== 4'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL b2b end: got cs=%b ready=%b expected 0000/1", cs, ready); end
    endtask

    task automatic test_async_reset();
        ale = 1'b1; ad = 8'h13; a = 12'h000; iom = 1'b1;
        @(posedge clk); #1;
        ale = 1'b0; rd = 1'b0;
        @(posedge clk); #1;
        vectors++; if (ready !== 1'b0 || cs !== 4'b1000) begin miscompares++; $display("FAIL areset setup: got cs=%b ready=%b expected 1000/0", cs, ready); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (address !== 20'h0 || cs !== 4'b0) begin miscompares++; $display("FAIL areset addr/cs: got %05h/%b expected 00000/0000", address, cs); end
        vectors++; if (ready !== 1'b1 || cycle_active !== 1'b0 || decode_err !== 1'b0) begin miscompares++; $display("FAIL areset flags: got ready=%b act=%b err=%b expected 1/0/0", ready, cycle_active, decode_err); end
        @(negedge clk);
        rd = 1'b1; iom = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_cycles("after_reset", '{20'h10000}, '{1'b0}, '{1'b0}, '{1'b1}, '{4'b0010}, '{2}, '{0});
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_regions();
        test_decode_err();
        test_abort();
        test_back_to_back();
        test_async_reset();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_cs_wait_ctrl.md
Name: bus_cs_wait_ctrl

Overview:
Bus-side cycle controller for the 8088 minimum-mode bus.
- Latches the multiplexed address on ALE.
- Decodes it against NUM_CS parametrised memory/IO regions and drives registered one-hot active-high chip selects on CS.
- Inserts a per-region number of wait states by holding READY low.
- Sits between the Processor-side pins (AD, A, ALE, IOM, RD, WR) and the Peripheral-side Address/CS signals, replacing fixed external CS decode.

Parameters:
NUM_CS, 4, number of decoded regions / CS lines
WAIT_W, 3, width of each wait-state count (max 2**WAIT_W-1 waits)
REGION_BASE, {20'h00000,20'h10000,20'h00000,20'h00010}, per-region base address (index 0 first)
REGION_MASK, {20'hF0000,20'hF0000,20'h0FFF0,20'h0FFF0}, per-region compare mask (1 = bit compared)
REGION_IO, 4'b1100, per-region space: bit i =1 IO, =0 memory (bit 0 = region 0)
REGION_WAIT, {3'd0,3'd2,3'd1,3'd3}, wait states per region (index 0 first)

Ports:
CLK  input  1  bus clock
RESET  input  1  asynchronous, active-low reset
ALE  input  1  address latch enable, active-high
IOM  input  1  1 = IO cycle, 0 = memory cycle
RD  input  1  read strobe, active-low
WR  input  1  write strobe, active-low
AD  input  8  low address byte (address phase)
A  input  12  address bits 19:8
Address  output  20  latched cycle address
CS  output  NUM_CS  one-hot active-high chip selects
READY  output  1  wait-state control to processor (0 = insert wait)
cycle_active  output  1  high from strobe detect until strobes released
decode_err  output  1  one-cycle pulse on unmapped or illegal cycle

Behaviour:
- Async reset (RESET=0) values, independent of CLK: Address=0, CS=0, READY=1, cycle_active=0, decode_err=0, state IDLE, wait counter 0.
- Address capture: Address <= {A,AD} on every rising edge where ALE=1. Address holds otherwise. IOM is sampled into io_q on the same edge.
- Decode (combinational, on Address/io_q):
  - Region i hits when (Address & MASK[i]) == (BASE[i] & MASK[i]) and io_q == REGION_IO[i].
  - IO regions compare only Address[15:0]; the MASK upper nibble is 0 for them.
  - Lowest index wins on overlap.
- FSM states IDLE, ADDR, WAIT, DONE:
  - IDLE: ALE=1 -> ADDR.
  - ADDR, strobe seen (RD=0 xor WR=0), region hit:
    - CS <= onehot(i) and cycle_active <= 1.
    - If REGION_WAIT[i]==0: READY stays 1, go to DONE.
    - Otherwise: READY <= 0, counter <= REGION_WAIT[i]-1, go to WAIT.
  - ADDR, strobe seen, no hit: decode_err pulse, CS stays 0, READY stays 1, cycle_active <= 1, go to DONE.
  - ADDR, RD=0 and WR=0 together: illegal. decode_err pulse, CS=0, go to DONE.
  - WAIT: counter decrements each edge. On the edge where counter==0: READY <= 1, go to DONE. READY is therefore low for exactly REGION_WAIT[i] clock cycles.
  - DONE: when RD=1 and WR=1 are sampled: CS <= 0, cycle_active <= 0, go to IDLE. If ALE=1 on that same edge, go to ADDR instead (back-to-back cycles).
- Abort: ALE=1 sampled in WAIT or DONE before the strobes release:
  - CS <= 0, READY <= 1, cycle_active <= 0, decode_err pulse, go to ADDR.
  - The new address is latched normally.
- ALE=1 in ADDR: re-latch the address and stay in ADDR.
- Latency: CS and cycle_active go high one edge after the strobe is sampled low. READY drops on that same edge.
- Outputs are registered only; no combinational path from inputs to outputs.

Decomposition:
- Package bus8088_pkg:
  - state enum (IDLE, ADDR, WAIT, DONE)
  - ADDR_W=20 and DATA_W=8 constants
  - region_cfg_t struct {base, mask, io, wait}
  - onehot helper function
- Sub-module bus_region_decode: combinational, parametrised on NUM_CS. Inputs Address and io_q; outputs hit, index, wait count.

Test Plan:
- Mem read 0x0_4123, ALE then RD=0 -> Address=0x04123, CS=4'b0001 next edge, READY never low, CS=0 one edge after RD=1.
- Mem write 0x1_2345 -> CS=4'b0010, READY low exactly 2 cycles, cycle_active high until WR=1.
- IO read port 0x0013 (IOM=1) -> CS=4'b1000, READY low 3 cycles. IO port 0x0005 -> CS=4'b0100, READY low 1 cycle.
- Unmapped mem 0xF_0000 with RD=0, and separately RD=WR=0 at 0x0_0000 -> decode_err one-cycle pulse, CS=0, READY=1.
- ALE=1 during WAIT of a region-1 cycle -> CS cleared, READY=1, decode_err pulse, new address latched.
- RESET=0 asserted mid-WAIT, asynchronously to CLK -> all outputs at reset values immediately. After release, a 0x1_0000 read behaves normally.
